asin_iter: RTL and testbench

- Sequential inverse of the team's combinational Q16.16 sine block.
- Takes a sine value X in Q16.16 (X[31:16] integer, X[15:0] fraction) and returns the angle in radians, in [-Pi/2, +Pi/2], also in Q16.16.
- Method: bisection over the angle. Each probe evaluates the same 5-term Taylor sine (x^1..x^9) on one shared multiplier and one constant divider.
- Sits beside the sine block in the fixed-point math library; start/done handshake for use by a sequencing controller.

---
 rtl/asin_iter.sv | 156 +++++++++++++++
 tb/tb_asin_iter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/asin_iter.sv
// Sequential Q16.16 arcsine: bisection over the angle, each probe evaluating the
// 5-term Taylor sine on one shared multiplier and one constant divider.
//
// state | meaning
// IDLE  | waiting for start
// CHECK | saturate |x| >= 1.0, else open the [-pi/2, +pi/2] bracket
// MID   | mid = (lo+hi)/2, reset power/accumulator
// TERM  | acc += +/- p / fac[t]
// MUL   | two multiply cycles: p = p*mid*mid
// CMP   | shrink bracket on sine(mid) vs x
// DONE  | publish result, pulse done
module asin_iter #(
    parameter int ITER = 18
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] x,
    output logic        busy,
    output logic        done,
    output logic [31:0] asin,
    output logic        sat
);

    localparam int ITW = $clog2(ITER + 1);
    localparam logic signed [31:0] HALF_PI = 32'sd102944;
    localparam logic signed [31:0] ONE     = 32'sd65536;
    localparam logic signed [31:0] NEG_ONE = -32'sd65536;

    typedef enum logic [2:0] {IDLE, CHECK, MID, TERM, MUL, CMP, DONE} state_t;

    state_t             state;
    logic signed [31:0] xr, lo, hi, mid, p, acc, result;
    logic [2:0]         t;
    logic               neg, mcnt, sat_r;
    logic [ITW-1:0]     it;

    logic signed [31:0] num, quot, mid_next;
    logic signed [63:0] p64, m64, prod;

    function automatic logic signed [31:0] fac(input logic [2:0] k);
        case (k)
            3'd0:    fac = 32'sd1;
            3'd1:    fac = 32'sd6;
            3'd2:    fac = 32'sd120;
            3'd3:    fac = 32'sd5040;
            3'd4:    fac = 32'sd362880;
            default: fac = 32'sd1;
        endcase
    endfunction

    // Division truncates toward zero, so negating before dividing matches -(p/fac).
    assign num      = neg ? -p : p;
    assign quot     = num / fac(t);
    assign mid_next = (lo + hi) >>> 1;
    assign p64      = p;
    assign m64      = mid;
    assign prod     = p64 * m64;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            asin   <= '0;
            sat    <= 1'b0;
            sat_r  <= 1'b0;
            xr     <= '0;
            lo     <= '0;
            hi     <= '0;
            mid    <= '0;
            p      <= '0;
            acc    <= '0;
            result <= '0;
            t      <= '0;
            neg    <= 1'b0;
            mcnt   <= 1'b0;
            it     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        xr    <= x;
                        busy  <= 1'b1;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (xr >= ONE) begin
                        result <= HALF_PI;
                        sat_r  <= 1'b1;
                        state  <= DONE;
                    end else if (xr <= NEG_ONE) begin
                        result <= -HALF_PI;
                        sat_r  <= 1'b1;
                        state  <= DONE;
                    end else begin
                        lo    <= -HALF_PI;
                        hi    <= HALF_PI;
                        it    <= '0;
                        sat_r <= 1'b0;
                        state <= MID;
                    end
                end
                MID: begin
                    mid   <= mid_next;
                    p     <= mid_next;
                    acc   <= '0;
                    t     <= '0;
                    neg   <= 1'b0;
                    state <= TERM;
                end
                TERM: begin
                    acc <= acc + quot;
                    neg <= ~neg;
                    if (t == 3'd4) begin
                        state <= CMP;
                    end else begin
                        mcnt  <= 1'b0;
                        state <= MUL;
                    end
                end
                MUL: begin
                    p    <= 32'(prod >>> 16);
                    mcnt <= ~mcnt;
                    if (mcnt) begin
                        t     <= t + 3'd1;
                        state <= TERM;
                    end
                end
                CMP: begin
                    if (acc < xr) lo <= mid;
                    else          hi <= mid;
                    it <= it + ITW'(1);
                    if (it == ITW'(ITER - 1)) begin
                        // Final answer is the upper bracket after this update.
                        result <= (acc < xr) ? hi : mid;
                        state  <= DONE;
                    end else begin
                        state <= MID;
                    end
                end
                DONE: begin
                    asin  <= result;
                    sat   <= sat_r;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_asin_iter.sv
// Bench for asin_iter: cycle-level behavioural model plus directed and random runs.
module tb_asin_iter;

    localparam int ITER    = 18;
    localparam int HALF_PI = 102944;
    localparam int LAT     = 2 + 15 * ITER;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] x;
    logic        busy, done, sat;
    logic [31:0] asin;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    asin_iter #(.ITER(ITER)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .x    (x),
        .busy (busy),
        .done (done),
        .asin (asin),
        .sat  (sat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got %0d expected %0d (time %0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sine_m(input int a);
        int     fac[5] = '{1, 6, 120, 5040, 362880};
        int     p = a;
        int     s = 0;
        longint pr;
        for (int k = 0; k < 5; k++) begin
            if (k % 2 == 0) s += p / fac[k];
            else            s -= p / fac[k];
            pr = longint'(p) * longint'(a);
            p  = int'(pr >>> 16);
            pr = longint'(p) * longint'(a);
            p  = int'(pr >>> 16);
        end
        return s;
    endfunction

    function automatic int asin_m(input int v);
        int lo, hi, m;
        if (v >= 65536)  return HALF_PI;
        if (v <= -65536) return -HALF_PI;
        lo = -HALF_PI;
        hi = HALF_PI;
        for (int i = 0; i < ITER; i++) begin
            m = (lo + hi) >>> 1;
            if (sine_m(m) < v) lo = m;
            else               hi = m;
        end
        return hi;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Transaction-level model: accept, fixed latency, publish.
    logic m_busy = 1'b0, m_done = 1'b0, m_sat = 1'b0, p_sat = 1'b0;
    int   m_asin = 0, p_res = 0, m_due = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_asin <= 0;
            m_sat  <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_busy && cyc == m_due) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_asin <= p_res;
                m_sat  <= p_sat;
            end else if (!m_busy && start) begin
                m_busy <= 1'b1;
                p_res  <= asin_m(int'(x));
                p_sat  <= (int'(x) >= 65536) || (int'(x) <= -65536);
                m_due  <= cyc + (((int'(x) >= 65536) || (int'(x) <= -65536)) ? 2 : LAT);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        chk(busy == m_busy, "busy", int'(busy), int'(m_busy));
        chk(done == m_done, "done", int'(done), int'(m_done));
        chk(sat == m_sat, "sat", int'(sat), int'(m_sat));
        chk(int'(asin) == m_asin, "asin", int'(asin), m_asin);
    end

    task automatic launch(input int v, output int t0);
        @(negedge clk);
        x     = v;
        start = 1'b1;
        @(posedge clk);
        #1 t0 = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int t0, output int lat);
        lat = -1;
        for (int i = 0; i < LAT + 20; i++) begin
            @(negedge clk);
            if (done) begin
                lat = cyc - t0;
                break;
            end
        end
        if (lat < 0) chk(1'b0, "done_timeout", lat, LAT);
    endtask

    task automatic run(input int v, output int res, output int lat);
        int t0;
        launch(v, t0);
        wait_done(t0, lat);
        res = int'(asin);
    endtask

    initial begin
        int res, res2, lat, t0, t1, nd, a, xs;
        rst   = 1'b0;
        start = 1'b0;
        x     = '0;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk(busy == 1'b0 && done == 1'b0 && sat == 1'b0 && asin == 32'd0, "reset_state", int'(asin), 0);
        rst = 1'b0;

        chk(asin_m(65536) == HALF_PI, "model_sat_pos", asin_m(65536), HALF_PI);
        chk(asin_m(-65536) == -HALF_PI, "model_sat_neg", asin_m(-65536), -HALF_PI);
        chk(iabs(asin_m(32768) - 34315) <= 3, "model_half", asin_m(32768), 34315);
        chk(sine_m(0) == 0, "model_sine0", sine_m(0), 0);

        // zero input, with busy over the whole operation
        launch(0, t0);
        nd = 0;
        for (int i = 1; i < LAT; i++) begin
            @(negedge clk);
            if (!busy) nd++;
        end
        chk(nd == 0, "busy_window", nd, 0);
        wait_done(t0, lat);
        chk(lat == LAT, "lat_zero", lat, LAT);
        chk(iabs(int'(asin)) <= 1 && sat == 1'b0, "asin_zero", int'(asin), 0);

        run(32768, res, lat);
        chk(iabs(res - 34315) <= 3, "asin_half", res, 34315);
        run(-32768, res2, lat);
        chk(iabs(res2 + 34315) <= 3, "asin_neg_half", res2, -34315);
        chk(iabs(res + res2) <= 1, "symmetry", res + res2, 0);

        run(65536, res, lat);
        chk(lat == 2, "lat_sat", lat, 2);
        chk(res == HALF_PI && sat == 1'b1, "sat_pos", res, HALF_PI);
        run(32'h8000_0000, res, lat);
        chk(res == -HALF_PI && sat == 1'b1, "sat_neg", res, -HALF_PI);
        run(65535, res, lat);
        chk(sat == 1'b0 && iabs(res - HALF_PI) <= 600, "near_one", res, HALF_PI);

        for (int i = 0; i < 20; i++) begin
            a  = int'($urandom_range(0, 2 * HALF_PI)) - HALF_PI;
            xs = sine_m(a);
            run(xs, res, lat);
            chk(iabs(res - a) <= 4, "round_trip", res, a);
        end
        for (int i = 0; i < 8; i++) begin
            run(int'($urandom_range(0, 140000)) - 70000, res, lat);
        end

        // starts during an operation are dropped
        launch(12345, t0);
        nd = 0;
        for (int i = 0; i < LAT + 10; i++) begin
            @(negedge clk);
            if (cyc - t0 == 4 || cyc - t0 == 99) begin
                start = 1'b1;
                x     = 32'd40000;
            end else begin
                start = 1'b0;
            end
            if (done) nd++;
        end
        start = 1'b0;
        chk(nd == 1, "single_done", nd, 1);
        chk(int'(asin) == asin_m(12345), "ignored_start_result", int'(asin), asin_m(12345));

        // start held across the done edge: accepted only on the following edge
        launch(20000, t0);
        repeat (LAT - 1) @(negedge clk);
        start = 1'b1;
        x     = -32'sd20000;
        @(negedge clk);
        chk(done == 1'b1 && busy == 1'b0, "done_edge_not_accepted", int'(busy), 0);
        @(posedge clk);
        #1 t1 = cyc;
        chk(busy == 1'b1, "next_edge_accepted", int'(busy), 1);
        @(negedge clk);
        start = 1'b0;
        wait_done(t1, lat);
        chk(lat == LAT, "lat_back_to_back", lat, LAT);
        chk(int'(asin) == asin_m(-20000), "back_to_back_result", int'(asin), asin_m(-20000));

        // asynchronous reset mid-operation
        launch(5000, t0);
        repeat (49) @(negedge clk);
        rst = 1'b1;
        #1;
        chk(busy == 1'b0 && done == 1'b0 && sat == 1'b0 && asin == 32'd0, "async_reset", int'(asin), 0);
        @(negedge clk);
        rst = 1'b0;
        nd  = 0;
        for (int i = 0; i < LAT + 30; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk(nd == 0, "no_done_after_reset", nd, 0);
        run(5000, res, lat);
        chk(lat == LAT, "lat_after_reset", lat, LAT);
        chk(res == asin_m(5000) && sat == 1'b0, "result_after_reset", res, asin_m(5000));

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
